// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the arbitrated UART transmitter and its helpers.
package uart_tx_arbiter_pkg;

  // Default clk cycles per serial bit.
  localparam int unsigned BaudDivDefault = 666;

  // Frame sequencer states; the encoding is shared with a future receiver.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } tx_state_e;

  // Round-robin pick: a lone requester wins; on a tie the one not granted last time wins.
  function automatic logic rr_pick(input logic v0, input logic v1, input logic last_id);
    if (v0 && v1) begin
      return ~last_id;
    end
    return v1;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud counter: counts 0..BAUD_DIV-1 while run is high and strobes tick on the last count.
module baud_tick_gen
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault,
  parameter int unsigned CNT_W    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(BAUD_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Strobe is combinational so the sequencer advances on the same edge the counter wraps.
  always_comb begin
    tick = run && (cnt_q == CntMax);
  end

  // Counter is held at zero whenever the sequencer is idle, so each frame starts aligned.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1 UART transmitter.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BaudDivDefault,
  parameter int unsigned CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id
);

  tx_state_e  state_q;
  logic       tx_q;
  logic       busy_q;
  logic       grant_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;

  logic       tick;
  logic       accept;
  logic       win_id;
  logic [7:0] win_data;

  baud_tick_gen #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baud_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .run  (busy_q),
    .tick (tick)
  );

  // Accept decision; suppressed during rst so an aborted frame cannot consume a byte.
  always_comb begin
    win_id     = rr_pick(req0_valid, req1_valid, grant_q);
    win_data   = win_id ? req1_data : req0_data;
    accept     = (state_q == StIdle) && !rst && (req0_valid || req1_valid);
    req0_ready = accept && !win_id;
    req1_ready = accept && win_id;
  end

  // Frame sequencer with registered line, busy and grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= 1'b1;
      idx_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            shift_q <= win_data;
            grant_q <= win_id;
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (tick) begin
            state_q <= StData;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            idx_q   <= 3'd0;
          end
        end
        StData: begin
          if (tick) begin
            // Index wraps 7 -> 0 as the last data bit completes.
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end
        end
        StStop: begin
          if (tick) begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table-driven frames, hand-written corner sequences and a
// randomized phase, all checked every cycle against a frame-timing reference model.
module tb_uart_tx_arbiter;

  localparam int B = 4;

  logic       clk;
  logic       rst;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       tx;
  logic       busy;
  logic       grant_id;

  uart_tx_arbiter #(
    .BAUD_DIV (B),
    .CNT_W    (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .tx         (tx),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the frame in flight is described only by its accept cycle and its
  // ten line bits; everything else follows from cycle arithmetic.
  int         m_k;
  int         m_t;
  logic       m_active;
  logic       m_grant;
  logic [9:0] m_bits;

  logic obs_r0, obs_r1, obs_tx, obs_busy, obs_grant;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       exp_id;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, m_k, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%02h, expected 0x%02h", name, m_k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, m_k, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare every output with the model, advance the model.
  task automatic cycle(input logic r, input logic a_v, input logic [7:0] a_d,
                       input logic b_v, input logic [7:0] b_d);
    logic idle, acc, win, e_tx;
    int   pos;
    @(posedge clk);
    #1;
    rst        = r;
    req0_valid = a_v;
    req0_data  = a_d;
    req1_valid = b_v;
    req1_data  = b_d;
    #3;
    idle = !m_active || (m_k >= m_t + 1 + 10 * B);
    if (idle) begin
      e_tx = 1'b1;
    end else begin
      pos  = (m_k - m_t - 1) / B;
      e_tx = m_bits[pos];
    end
    acc = idle && !r && (a_v || b_v);
    win = (a_v && b_v) ? !m_grant : b_v;
    check1("req0_ready", req0_ready, acc && !win);
    check1("req1_ready", req1_ready, acc && win);
    check1("tx", tx, e_tx);
    check1("busy", busy, !idle);
    check1("grant_id", grant_id, m_grant);
    obs_r0    = req0_ready;
    obs_r1    = req1_ready;
    obs_tx    = tx;
    obs_busy  = busy;
    obs_grant = grant_id;
    if (r) begin
      m_active = 1'b0;
      m_grant  = 1'b1;
    end else if (acc) begin
      m_active = 1'b1;
      m_t      = m_k;
      m_grant  = win;
      m_bits   = {1'b1, (win ? b_d : a_d), 1'b0};
    end
    m_k++;
  endtask

  // Present a request until accepted, then decode the serial frame from the line.
  task automatic run_frame(input logic a_v, input logic [7:0] a_d, input logic b_v,
                           input logic [7:0] b_d, input logic hold, input logic scramble,
                           input logic exp_id, input logic [7:0] exp_byte, output int lat);
    int         waited;
    int         busy_cnt;
    logic [9:0] line;
    logic [7:0] bd;
    waited = 0;
    cycle(1'b0, a_v, a_d, b_v, b_d);
    while (!(obs_r0 || obs_r1) && waited < 50) begin
      waited++;
      cycle(1'b0, a_v, a_d, b_v, b_d);
    end
    lat = waited;
    check1("accept_seen", obs_r0 || obs_r1, 1'b1);
    check1("accept_id", obs_r1, exp_id);
    busy_cnt = 0;
    line     = '0;
    bd       = b_d;
    for (int i = 0; i < 10 * B; i++) begin
      if (scramble) bd = 8'($urandom);
      cycle(1'b0, hold ? a_v : 1'b0, a_d, hold ? b_v : 1'b0, bd);
      if (obs_busy) busy_cnt++;
      if (i % B == B / 2) line[i / B] = obs_tx;
      if (i == 0) check1("grant_after_accept", obs_grant, exp_id);
    end
    check1("start_bit", line[0], 1'b0);
    check1("stop_bit", line[9], 1'b1);
    check8("frame_byte", line[8:1], exp_byte);
    check_int("busy_len", busy_cnt, 10 * B);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    int   rcount;
    logic rv0, rv1;

    vecs[0] = '{v0: 1'b1, d0: 8'hA5, v1: 1'b0, d1: 8'h00, exp_id: 1'b0, exp_byte: 8'hA5};
    vecs[1] = '{v0: 1'b0, d0: 8'h00, v1: 1'b1, d1: 8'h3C, exp_id: 1'b1, exp_byte: 8'h3C};
    vecs[2] = '{v0: 1'b1, d0: 8'h11, v1: 1'b1, d1: 8'h22, exp_id: 1'b0, exp_byte: 8'h11};
    vecs[3] = '{v0: 1'b1, d0: 8'h5A, v1: 1'b1, d1: 8'hC3, exp_id: 1'b1, exp_byte: 8'hC3};
    vecs[4] = '{v0: 1'b1, d0: 8'hFF, v1: 1'b0, d1: 8'h77, exp_id: 1'b0, exp_byte: 8'hFF};
    vecs[5] = '{v0: 1'b0, d0: 8'h99, v1: 1'b1, d1: 8'h00, exp_id: 1'b1, exp_byte: 8'h00};
    vecs[6] = '{v0: 1'b1, d0: 8'h80, v1: 1'b1, d1: 8'h01, exp_id: 1'b0, exp_byte: 8'h80};
    vecs[7] = '{v0: 1'b1, d0: 8'h01, v1: 1'b0, d1: 8'hEE, exp_id: 1'b0, exp_byte: 8'h01};

    rst        = 1'b1;
    req0_valid = 1'b0;
    req0_data  = 8'h00;
    req1_valid = 1'b0;
    req1_data  = 8'h00;
    repeat (3) @(posedge clk);
    m_k      = 0;
    m_t      = 0;
    m_active = 1'b0;
    m_grant  = 1'b1;
    m_bits   = '1;

    // Reset state, one idle cycle.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Table of single frames applied back to back; grant history runs through the table.
    for (int v = 0; v < 8; v++) begin
      run_frame(vecs[v].v0, vecs[v].d0, vecs[v].v1, vecs[v].d1, 1'b0, 1'b0,
                vecs[v].exp_id, vecs[v].exp_byte, lat);
    end

    // Both valid from reset: alternate 0,1,0,1 with no idle gap between frames.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int f = 0; f < 4; f++) begin
      run_frame(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, f[0], f[0] ? 8'h22 : 8'h11, lat);
      check_int("back_to_back_gap", lat, 0);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);

    // Reset on cycle 13 of a frame, then a clean req1 frame.
    cycle(1'b0, 1'b1, 8'h96, 1'b0, 8'h00);
    check1("abort_frame_accept", obs_r0, 1'b1);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 8'h3C);
    check1("no_ready_in_rst", obs_r1, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    check1("abort_tx_high", obs_tx, 1'b1);
    check1("abort_busy_low", obs_busy, 1'b0);
    run_frame(1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, lat);

    // Data scrambled every cycle after accept must not disturb the frame.
    run_frame(1'b0, 8'h00, 1'b1, 8'hC6, 1'b0, 1'b1, 1'b1, 8'hC6, lat);

    // One-cycle valid pulse while busy is simply dropped.
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 8'h5A);
    check1("pulse_setup_accept", obs_r1, 1'b1);
    rcount = 0;
    for (int i = 0; i < 10 * B + 5; i++) begin
      cycle(1'b0, (i == 7), 8'hEE, 1'b0, 8'h00);
      if (obs_r0 || obs_r1) rcount++;
    end
    check_int("pulse_no_ready", rcount, 0);
    check1("pulse_idle_after", obs_busy, 1'b0);

    // Randomized traffic with occasional resets, checked against the model every cycle.
    rv0 = 1'b0;
    rv1 = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) rv0 = !rv0;
      if ($urandom_range(0, 3) == 0) rv1 = !rv1;
      cycle(($urandom_range(0, 299) == 0), rv0, 8'($urandom), rv1, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter BAUD_DIV, default 666, clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of the internal baud counter.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 has a byte to send.
REQ-006 req0_data  input  8  requester 0 byte; sampled only on accept.
REQ-007 req0_ready  output  1  byte from requester 0 accepted this cycle.
REQ-008 req1_valid  input  1  requester 1 has a byte to send.
REQ-009 req1_data  input  8  requester 1 byte; sampled only on accept.
REQ-010 req1_ready  output  1  byte from requester 1 accepted this cycle.
REQ-011 tx  output  1  serial line, 8N1, idle high, registered.
REQ-012 busy  output  1  high while a frame is in progress (state != IDLE).
REQ-013 grant_id  output  1  index of the requester most recently accepted.

Function
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 An accept SHALL occur in any IDLE cycle where at least one valid is high: reqN_ready high for exactly that one cycle, and combinational from state, valids and the round-robin pointer.
REQ-016 Arbitration: a single valid requester wins; if both are valid, the requester not equal to grant_id wins (round robin).
REQ-017 On accept: the winner's data is latched, grant_id is updated, the baud counter clears, and the state moves to START.
REQ-018 tx SHALL be low from accept cycle t+1 through t+BAUD_DIV (start bit).
REQ-019 DATA SHALL shift 8 bits LSB first, each bit held for exactly BAUD_DIV cycles, with a 3-bit index wrapping from 7 to STOP.
REQ-020 STOP SHALL drive tx high for BAUD_DIV cycles, then return to IDLE at cycle t+1+10*BAUD_DIV.
REQ-021 A new accept is allowed in that same IDLE cycle, so back-to-back frames have no extra idle bits.
REQ-022 The baud counter SHALL count 0..BAUD_DIV-1 and wrap. The bit-advance strobe fires at count BAUD_DIV-1. The counter runs only outside IDLE.
REQ-023 A requester dropping valid before ready is legal: no grant, no side effect.
REQ-024 Changes to reqN_data while the state is not IDLE SHALL NOT affect the frame in flight.
REQ-025 A valid held through a whole frame SHALL be serviced at the next IDLE cycle, subject to round robin.
REQ-026 busy SHALL equal (state != IDLE), registered together with the state.

Reset
REQ-027 On rst: state = IDLE, tx = 1, busy = 0, grant_id = 1 (so requester 0 wins the first tie), baud counter = 0, bit index = 0, shift register = 0.
REQ-028 rst asserted mid-frame SHALL abort the frame: tx is high from the next cycle, and no ready is issued during the rst cycle.
REQ-029 An accept is possible in the first cycle after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the state encoding (2-bit IDLE=0, START=1, DATA=2, STOP=3) and the default BAUD_DIV constant.
REQ-031 The baud counter and strobe SHALL be one sub-module, baud_tick_gen (inputs clk, rst, run; output tick), reused by a future receiver.
REQ-032 Target size: 150-250 lines of RTL in total.

Verification (BAUD_DIV=4)
REQ-033 req0 sends 0xA5 alone -> req0_ready pulses once; tx reads 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles; busy high for 40 cycles.
REQ-034 Both valid from reset with 0x11 / 0x22 -> 0x11 sent first, then 0x22 starting on the very next IDLE cycle; grant_id goes 0 then 1.
REQ-035 Both valid continuously for 4 frames -> grants alternate 0,1,0,1; no gap between the stop bit and the next start bit.
REQ-036 rst pulsed at cycle 13 of a frame -> tx is 1 from the next cycle, busy is 0; the following req1 byte 0x3C is sent correctly.
REQ-037 req1_data changed every cycle during a frame -> the serialized byte equals the value sampled on the accept cycle.
REQ-038 req0_valid pulsed for one cycle while busy -> no ready, no frame sent for it.
